gyruss_sndcmd_tx: RTL

Main-CPU-side transmitter for the sound-command link. It queues command bytes written by the main CPU in a small FIFO and presents each byte on SNDNO. It then raises SNDRQ with guaranteed setup, pulse width, optional acknowledge wait and inter-command gap, so the sound board's rising-edge latch never misses or merges commands. Exposes a status byte for main-CPU polling.

---
 rtl/gyruss_sndcmd_if.sv | 25 ++
 rtl/gyruss_sndcmd_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gyruss_sndcmd_if.sv
// Sound-command link bundle: CPU write/status side plus the strobe/byte pair to the sound board.
// Latency: none, wiring only.
// Backpressure: none; the transmitter absorbs writes in its FIFO and reports overflow in STAT.
interface gyruss_sndcmd_if;
    logic       WR;
    logic [7:0] WDAT;
    logic       STRD;
    logic [7:0] STAT;
    logic       ACK;
    logic       SNDRQ;
    logic [7:0] SNDNO;
    logic       BUSY;

    // Side that issues commands and acknowledges (CPU plus sound board)
    modport master (
        output WR, WDAT, STRD, ACK,
        input  STAT, SNDRQ, SNDNO, BUSY
    );

    // Transmitter side
    modport slave (
        input  WR, WDAT, STRD, ACK,
        output STAT, SNDRQ, SNDNO, BUSY
    );
endinterface

// File: rtl/gyruss_sndcmd_tx.sv
// Main-CPU sound-command transmitter: queues bytes and emits each on SNDNO with a timed SNDRQ strobe.
// Latency: WR at cycle t -> SNDNO at t+2, SNDRQ rise at t+SETUP+2; STAT is combinational from flops.
// Backpressure: none toward the CPU; a write into a full FIFO with no pop is dropped and sets OVF.
module gyruss_sndcmd_tx #(
    parameter int DEPTH_LOG2  = 3,
    parameter int SETUP       = 4,
    parameter int HOLD        = 16,
    parameter int GAP         = 16,
    parameter bit ACK_EN      = 1'b1,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic           MCLK,
    input  logic           RESET,
    gyruss_sndcmd_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int M1    = (SETUP > HOLD) ? SETUP : HOLD;
    localparam int M2    = (GAP > M1) ? GAP : M1;
    localparam int CMAX  = (ACK_TIMEOUT > M2) ? ACK_TIMEOUT : M2;
    localparam int CW    = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HOLD,
        S_WAIT_ACK,
        S_GAP
    } state_t;

    // FIFO storage and pointers
    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, to_q, to_d;

    // ACK synchroniser and edge detect
    logic ack_s1_q, ack_s2_q, ack_s3_q;
    logic ackr;

    // Sequencer
    state_t        state_q, state_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic          sndrq_q, sndrq_d;
    logic [7:0]    sndno_q, sndno_d;
    logic          ackseen_q, ackseen_d;
    logic          to_set;

    logic       empty, full, pop, wr_acc, ovf_set;
    logic [3:0] stat_cnt;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    // Pop is decided from registered count, so a byte written while empty waits one cycle
    assign pop      = (state_q == S_IDLE) && !empty;
    assign wr_acc   = bus.WR && (!full || pop);
    assign ovf_set  = bus.WR && full && !pop;
    assign ackr     = ack_s2_q & ~ack_s3_q;
    assign stat_cnt = 4'(cnt_q);

    assign bus.STAT  = {ovf_q, to_q, full, empty, stat_cnt};
    assign bus.SNDRQ = sndrq_q;
    assign bus.SNDNO = sndno_q;
    assign bus.BUSY  = (state_q != S_IDLE);

    // FIFO bookkeeping and sticky status flags (a set in the same cycle as STRD wins)
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (wr_acc) begin
            mem_d[wp_q] = bus.WDAT;
            wp_d        = wp_q + 1'b1;
        end
        if (pop) begin
            rp_d = rp_q + 1'b1;
        end
        if (wr_acc && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!wr_acc && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        ovf_d = (ovf_q & ~bus.STRD) | ovf_set;
        to_d  = (to_q & ~bus.STRD) | to_set;
    end

    // Request sequencer: setup, hold, optional acknowledge wait, then inter-command gap
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        sndrq_d   = sndrq_q;
        sndno_d   = sndno_q;
        ackseen_d = ackseen_q;
        to_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    sndno_d = mem_q[rp_q];
                    tmr_d   = CW'(SETUP - 1);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                sndrq_d = 1'b0;
                if (tmr_q == '0) begin
                    sndrq_d   = 1'b1;
                    tmr_d     = CW'(HOLD - 1);
                    ackseen_d = 1'b0;
                    state_d   = S_HOLD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_HOLD: begin
                sndrq_d = 1'b1;
                if (ackr) begin
                    ackseen_d = 1'b1;
                end
                if (tmr_q == '0) begin
                    sndrq_d = 1'b0;
                    if (ACK_EN) begin
                        tmr_d   = CW'(ACK_TIMEOUT - 1);
                        state_d = S_WAIT_ACK;
                    end else begin
                        tmr_d   = CW'(GAP - 1);
                        state_d = S_GAP;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_WAIT_ACK: begin
                sndrq_d = 1'b0;
                if (ackseen_q || ackr) begin
                    tmr_d   = CW'(GAP - 1);
                    state_d = S_GAP;
                end else if (tmr_q == '0) begin
                    to_set  = 1'b1;
                    tmr_d   = CW'(GAP - 1);
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_GAP: begin
                sndrq_d = 1'b0;
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                sndrq_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO, flags and ACK synchroniser registers; reset discards queued bytes
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            mem_q    <= '{default: 8'h00};
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
            ack_s3_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
            ack_s1_q <= bus.ACK;
            ack_s2_q <= ack_s1_q;
            ack_s3_q <= ack_s2_q;
        end
    end

    // Sequencer state and registered outputs; reset drops SNDRQ immediately
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            sndrq_q   <= 1'b0;
            sndno_q   <= 8'h00;
            ackseen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            sndrq_q   <= sndrq_d;
            sndno_q   <= sndno_d;
            ackseen_q <= ackseen_d;
        end
    end
endmodule
